// File: rtl/arm_defs_pkg.sv
// ARM exception-entry definitions shared by the sequencer and its priority encoder:
// processor mode encodings, vector offsets, exception one-hot codes, CPSR bit indices.
package arm_defs_pkg;

    // Exception indices; bit k of every 6-bit request/ack vector is exception k.
    // Lower index means higher priority.
    localparam int NUM_EXC  = 6;
    localparam int EXC_DABT = 0;
    localparam int EXC_FIQ  = 1;
    localparam int EXC_IRQ  = 2;
    localparam int EXC_PABT = 3;
    localparam int EXC_UND  = 4;
    localparam int EXC_SWI  = 5;

    localparam logic [NUM_EXC-1:0] EXC_DABT_OH = 6'b1 << EXC_DABT;
    localparam logic [NUM_EXC-1:0] EXC_FIQ_OH  = 6'b1 << EXC_FIQ;
    localparam logic [NUM_EXC-1:0] EXC_IRQ_OH  = 6'b1 << EXC_IRQ;
    localparam logic [NUM_EXC-1:0] EXC_PABT_OH = 6'b1 << EXC_PABT;
    localparam logic [NUM_EXC-1:0] EXC_UND_OH  = 6'b1 << EXC_UND;
    localparam logic [NUM_EXC-1:0] EXC_SWI_OH  = 6'b1 << EXC_SWI;

    // CPSR bit positions
    localparam int CPSR_I    = 7;
    localparam int CPSR_F    = 6;
    localparam int CPSR_T    = 5;
    localparam int CPSR_M_HI = 4;
    localparam int CPSR_M_LO = 0;

    // Processor mode encodings (CPSR[4:0])
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;

    // Vector offsets from the vector table base
    localparam logic [31:0] VEC_UND  = 32'h0000_0004;
    localparam logic [31:0] VEC_SWI  = 32'h0000_0008;
    localparam logic [31:0] VEC_PABT = 32'h0000_000C;
    localparam logic [31:0] VEC_DABT = 32'h0000_0010;
    localparam logic [31:0] VEC_IRQ  = 32'h0000_0018;
    localparam logic [31:0] VEC_FIQ  = 32'h0000_001C;

    // Register-file indices written by the sequencer
    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    // Link-register offset for every exception except data abort
    localparam logic [31:0] LR_OFS_DEFAULT = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CPSR,
        ST_EVAL,
        ST_SET_MODE,
        ST_SAVE_SPSR,
        ST_WR_LR,
        ST_WR_PC,
        ST_DONE
    } seq_state_t;

    // Mode entered for a one-hot exception code
    function automatic logic [4:0] exc_mode(input logic [NUM_EXC-1:0] code);
        case (code)
            EXC_FIQ_OH:              return MODE_FIQ;
            EXC_IRQ_OH:              return MODE_IRQ;
            EXC_DABT_OH, EXC_PABT_OH: return MODE_ABT;
            EXC_UND_OH:              return MODE_UND;
            EXC_SWI_OH:              return MODE_SVC;
            default:                 return MODE_SVC;
        endcase
    endfunction

    // Vector offset for a one-hot exception code
    function automatic logic [31:0] exc_vector(input logic [NUM_EXC-1:0] code);
        case (code)
            EXC_UND_OH:  return VEC_UND;
            EXC_SWI_OH:  return VEC_SWI;
            EXC_PABT_OH: return VEC_PABT;
            EXC_DABT_OH: return VEC_DABT;
            EXC_IRQ_OH:  return VEC_IRQ;
            EXC_FIQ_OH:  return VEC_FIQ;
            default:     return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/exc_priority_encoder.sv
// Combinational priority pick: the lowest-index set bit of the masked request
// vector wins (DABT > FIQ > IRQ > PABT > UND > SWI).
module exc_priority_encoder
    import arm_defs_pkg::*;
(
    input  logic [NUM_EXC-1:0] masked_req_i,
    output logic [NUM_EXC-1:0] taken_o,
    output logic               valid_o
);

    // x & -x isolates the lowest set bit, which is the highest-priority request.
    assign taken_o = masked_req_i & (~masked_req_i + 6'd1);
    assign valid_o = |masked_req_i;

endmodule

// File: rtl/exception_entry_sequencer.sv
// ARM exception-entry sequencer. Takes over the register-file write and CPSR
// ports while busy and walks: read CPSR, pick exception, set mode/I/F, save the
// old CPSR into the new mode's SPSR, write LR, load the vector into PC, ack.
// Every output is registered and reflects the state the FSM is currently in.
module exception_entry_sequencer
    import arm_defs_pkg::*;
#(
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0000,
    parameter logic [31:0] DABT_LR_OFS = 32'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dabt_req,
    input  logic        fiq_req,
    input  logic        irq_req,
    input  logic        pabt_req,
    input  logic        und_req,
    input  logic        swi_req,
    input  logic [31:0] cur_pc,
    output logic [5:0]  exc_ack,
    output logic        stall,
    output logic        rf_write_en,
    output logic [3:0]  rf_write_reg,
    output logic [31:0] rf_write_value,
    output logic        rf_write_restore_from_SPSR,
    output logic        rf_cpsr_read_en,
    input  logic [31:0] rf_cpsr_read_value,
    output logic        rf_cpsr_write_en,
    output logic [31:0] rf_cpsr_write_value,
    output logic        rf_spsr_write_en,
    output logic [31:0] rf_spsr_write_value
);

    seq_state_t          state_q;
    logic [NUM_EXC-1:0]  req_q;
    logic [31:0]         old_cpsr_q;
    logic [NUM_EXC-1:0]  code_q;

    logic [5:0]          exc_ack_q;
    logic                stall_q;
    logic                rf_write_en_q;
    logic [3:0]          rf_write_reg_q;
    logic [31:0]         rf_write_value_q;
    logic                rf_cpsr_read_en_q;
    logic                rf_cpsr_write_en_q;
    logic [31:0]         rf_cpsr_write_value_q;
    logic                rf_spsr_write_en_q;
    logic [31:0]         rf_spsr_write_value_q;

    logic [NUM_EXC-1:0]  req_in;
    logic [NUM_EXC-1:0]  cpsr_mask;
    logic [NUM_EXC-1:0]  masked_req;
    logic [NUM_EXC-1:0]  taken;
    logic                taken_valid;
    logic [31:0]         new_cpsr;
    logic [31:0]         lr_value;
    logic [31:0]         pc_value;

    assign req_in = {swi_req, und_req, pabt_req, irq_req, fiq_req, dabt_req};

    // IRQ/FIQ are gated by the I/F bits of the CPSR being returned in EVAL.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        cpsr_mask          = '0;
        cpsr_mask[EXC_IRQ] = rf_cpsr_read_value[CPSR_I];
        cpsr_mask[EXC_FIQ] = rf_cpsr_read_value[CPSR_F];
    end

    assign masked_req = req_q & ~cpsr_mask;

    exc_priority_encoder u_prio (
        .masked_req_i (masked_req),
        .taken_o      (taken),
        .valid_o      (taken_valid)
    );

    // New CPSR: enter the exception mode, disable IRQ, back to ARM state; FIQ also disables FIQ.
    always_comb begin
        new_cpsr                       = rf_cpsr_read_value;
        new_cpsr[CPSR_M_HI:CPSR_M_LO]  = exc_mode(taken);
        new_cpsr[CPSR_I]               = 1'b1;
        new_cpsr[CPSR_T]               = 1'b0;
        if (taken == EXC_FIQ_OH) begin
            new_cpsr[CPSR_F] = 1'b1;
        end
    end

    // Return address and vector; both adds wrap modulo 2^32.
    assign lr_value = cur_pc + ((code_q == EXC_DABT_OH) ? DABT_LR_OFS : LR_OFS_DEFAULT);
    assign pc_value = VECTOR_BASE + exc_vector(code_q);

    // Sequencing FSM; outputs are loaded on the transition into the state that owns them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q               <= ST_IDLE;
            req_q                 <= '0;
            old_cpsr_q            <= '0;
            code_q                <= '0;
            exc_ack_q             <= '0;
            stall_q               <= 1'b0;
            rf_write_en_q         <= 1'b0;
            rf_write_reg_q        <= '0;
            rf_write_value_q      <= '0;
            rf_cpsr_read_en_q     <= 1'b0;
            rf_cpsr_write_en_q    <= 1'b0;
            rf_cpsr_write_value_q <= '0;
            rf_spsr_write_en_q    <= 1'b0;
            rf_spsr_write_value_q <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments; the defaults below are overridden by the later assignment in the case arm, so each strobe lives exactly one cycle.
            exc_ack_q             <= '0;
            rf_write_en_q         <= 1'b0;
            rf_write_reg_q        <= '0;
            rf_write_value_q      <= '0;
            rf_cpsr_read_en_q     <= 1'b0;
            rf_cpsr_write_en_q    <= 1'b0;
            rf_cpsr_write_value_q <= '0;
            rf_spsr_write_en_q    <= 1'b0;
            rf_spsr_write_value_q <= '0;

            case (state_q)
                ST_IDLE: begin
                    if (|req_in) begin
                        req_q             <= req_in;
                        state_q           <= ST_RD_CPSR;
                        stall_q           <= 1'b1;
                        rf_cpsr_read_en_q <= 1'b1;
                    end
                end
                ST_RD_CPSR: begin
                    state_q <= ST_EVAL;
                end
                ST_EVAL: begin
                    old_cpsr_q <= rf_cpsr_read_value;
                    if (taken_valid) begin
                        code_q                <= taken;
                        state_q               <= ST_SET_MODE;
                        rf_cpsr_write_en_q    <= 1'b1;
                        rf_cpsr_write_value_q <= new_cpsr;
                    end else begin
                        state_q <= ST_IDLE;
                        stall_q <= 1'b0;
                    end
                end
                ST_SET_MODE: begin
                    // The register file is now in the new mode, so its SPSR is the banked one.
                    state_q               <= ST_SAVE_SPSR;
                    rf_spsr_write_en_q    <= 1'b1;
                    rf_spsr_write_value_q <= old_cpsr_q;
                end
                ST_SAVE_SPSR: begin
                    state_q          <= ST_WR_LR;
                    rf_write_en_q    <= 1'b1;
                    rf_write_reg_q   <= REG_LR;
                    rf_write_value_q <= lr_value;
                end
                ST_WR_LR: begin
                    state_q          <= ST_WR_PC;
                    rf_write_en_q    <= 1'b1;
                    rf_write_reg_q   <= REG_PC;
                    rf_write_value_q <= pc_value;
                end
                ST_WR_PC: begin
                    state_q   <= ST_DONE;
                    exc_ack_q <= code_q;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    stall_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign exc_ack                    = exc_ack_q;
    assign stall                      = stall_q;
    assign rf_write_en                = rf_write_en_q;
    assign rf_write_reg               = rf_write_reg_q;
    assign rf_write_value             = rf_write_value_q;
    assign rf_write_restore_from_SPSR = 1'b0;
    assign rf_cpsr_read_en            = rf_cpsr_read_en_q;
    assign rf_cpsr_write_en           = rf_cpsr_write_en_q;
    assign rf_cpsr_write_value        = rf_cpsr_write_value_q;
    assign rf_spsr_write_en           = rf_spsr_write_en_q;
    assign rf_spsr_write_value        = rf_spsr_write_value_q;

endmodule
